// File: rtl/fwd_pkg.sv
// Shared types for the forwarding scoreboard.
//   cls_e    : result class of the EX instruction (ALU / LOAD / MUL, 3 = ALU)
//   slot_t   : one in-flight destination entry {v, rd, avail}
//   avail_of : first slot at which a result of a given class is forwardable
package fwd_pkg;

  localparam int unsigned RD_W    = 5;
  // Wide enough for any practical STAGES; the top truncates to SEL_W on output.
  localparam int unsigned AVAIL_W = 8;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_MUL  = 2'd2,
    CLS_RSVD = 2'd3
  } cls_e;

  typedef struct packed {
    logic               v;
    logic [RD_W-1:0]    rd;
    logic [AVAIL_W-1:0] avail;
  } slot_t;

  // Class to first-forwardable slot; the reserved encoding behaves as ALU.
  function automatic logic [AVAIL_W-1:0] avail_of(input logic [1:0] cls,
                                                  input int unsigned mul_lat);
    logic [AVAIL_W-1:0] w_res;
    case (cls)
      CLS_LOAD: w_res = AVAIL_W'(2);
      CLS_MUL:  w_res = AVAIL_W'(mul_lat);
      default:  w_res = AVAIL_W'(1);
    endcase
    return w_res;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Youngest-first producer search for one EX source operand.
//   i_slots   : shadow slots, index 0 = slot 1 (youngest)
//   i_rs      : source register of this operand
//   o_sel     : 0 = register file, k = forward from slot k
//   o_pending : youngest producer exists but its result is not yet available
module fwd_match
  import fwd_pkg::*;
#(
  parameter int unsigned STAGES = 3,
  parameter int unsigned SEL_W  = 2
) (
  input  slot_t            i_slots [STAGES],
  input  logic [RD_W-1:0]  i_rs,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_pending
);

  logic               w_hit;
  logic [AVAIL_W-1:0] w_k;
  logic [AVAIL_W-1:0] w_avail;

  // Scan oldest to youngest so the last hit written is the youngest producer.
  always_comb begin
    w_hit     = 1'b0;
    w_k       = '0;
    w_avail   = '0;
    o_sel     = '0;
    o_pending = 1'b0;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      if (i_slots[i].v && (i_slots[i].rd == i_rs)) begin
        w_hit   = 1'b1;
        w_k     = AVAIL_W'(i + 1);
        w_avail = i_slots[i].avail;
      end
    end
    // x0 is hardwired zero and never forwarded.
    if (w_hit && (i_rs != '0)) begin
      if (w_k >= w_avail) begin
        o_sel = SEL_W'(w_k);
      end else begin
        o_pending = 1'b1;
      end
    end
  end

endmodule

// File: rtl/forward_scoreboard.sv
// Parametrised forwarding / hazard unit beside the ID/EX register.
// Tracks in-flight destinations for STAGES slots after EX and produces
// per-source forward selects, a stall request and a stall-cycle counter.
//   clk_i, rst_i (sync, active-low)
//   ex_valid_i, ex_wb_i, ex_rd_i, ex_class_i, ex_rs_i : EX instruction
//   hold_i  : global freeze, flush_i : squash EX instruction
//   fwd_sel_o, stall_o (combinational), stall_cnt_o (saturating)
module forward_scoreboard
  import fwd_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned STAGES  = 3,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned SEL_W   = $clog2(STAGES + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     ex_valid_i,
  input  logic                     ex_wb_i,
  input  logic [RD_W-1:0]          ex_rd_i,
  input  logic [1:0]               ex_class_i,
  input  logic [NUM_SRC*RD_W-1:0]  ex_rs_i,
  input  logic                     hold_i,
  input  logic                     flush_i,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel_o,
  output logic                     stall_o,
  output logic [31:0]              stall_cnt_o
);

  localparam int unsigned CNT_W = 32;

  slot_t              r_slots [STAGES];
  logic [CNT_W-1:0]   r_stall_cnt;
  slot_t              w_cap;
  logic [NUM_SRC-1:0] w_pending;
  logic               w_stall;

  // One priority matcher per EX source operand.
  for (genvar s = 0; s < int'(NUM_SRC); s++) begin : g_src
    fwd_match #(
      .STAGES (STAGES),
      .SEL_W  (SEL_W)
    ) u_match (
      .i_slots   (r_slots),
      .i_rs      (ex_rs_i[s*RD_W +: RD_W]),
      .o_sel     (fwd_sel_o[s*SEL_W +: SEL_W]),
      .o_pending (w_pending[s])
    );
  end

  // A bubble (stall) or squashed instruction enters slot 1 as invalid.
  always_comb begin
    w_stall     = ex_valid_i & (|w_pending);
    w_cap       = '0;
    w_cap.v     = ex_valid_i & ex_wb_i & (ex_rd_i != '0) & ~flush_i & ~w_stall;
    w_cap.rd    = ex_rd_i;
    w_cap.avail = avail_of(ex_class_i, MUL_LAT);
  end

  assign stall_o     = w_stall;
  assign stall_cnt_o = r_stall_cnt;

  // Shadow shift register and stall counter; both frozen while hold_i is high.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        r_slots[i] <= '0;
      end
      r_stall_cnt <= '0;
    end else if (!hold_i) begin
      r_slots[0] <= w_cap;
      for (int i = 1; i < int'(STAGES); i++) begin
        r_slots[i] <= r_slots[i-1];
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Self-checking bench for forward_scoreboard: directed scenarios plus a
// randomized run against an age-based producer model.
module tb_forward_scoreboard;

  localparam int NUM_SRC = 2;
  localparam int STAGES  = 3;
  localparam int MUL_LAT = 3;
  localparam int SEL_W   = $clog2(STAGES + 1);

  logic                     clk_i = 1'b0;
  logic                     rst_i = 1'b0;
  logic                     ex_valid_i = 1'b0;
  logic                     ex_wb_i = 1'b0;
  logic [4:0]               ex_rd_i = '0;
  logic [1:0]               ex_class_i = '0;
  logic [NUM_SRC*5-1:0]     ex_rs_i = '0;
  logic                     hold_i = 1'b0;
  logic                     flush_i = 1'b0;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_o;
  logic                     stall_o;
  logic [31:0]              stall_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  forward_scoreboard #(
    .NUM_SRC (NUM_SRC),
    .STAGES  (STAGES),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ex_valid_i  (ex_valid_i),
    .ex_wb_i     (ex_wb_i),
    .ex_rd_i     (ex_rd_i),
    .ex_class_i  (ex_class_i),
    .ex_rs_i     (ex_rs_i),
    .hold_i      (hold_i),
    .flush_i     (flush_i),
    .fwd_sel_o   (fwd_sel_o),
    .stall_o     (stall_o),
    .stall_cnt_o (stall_cnt_o)
  );

  // Model: list of captured producers with the non-held cycle they were born in.
  // A producer's slot number is simply its age in non-held cycles.
  typedef struct {
    logic [4:0] rd;
    int         lat;
    longint     birth;
  } prod_t;

  prod_t       q[$];
  longint      m_tick = 0;
  logic [31:0] m_cnt  = '0;

  function automatic int lat_of(input logic [1:0] c);
    if (c == 2'd1) return 2;
    if (c == 2'd2) return MUL_LAT;
    return 1;
  endfunction

  function automatic logic [4:0] rs_of(input int s);
    return ex_rs_i[s*5 +: 5];
  endfunction

  function automatic int sel_of(input int s);
    return int'(fwd_sel_o[s*SEL_W +: SEL_W]);
  endfunction

  function automatic void m_src(input logic [4:0] rs, output int sel, output bit pend);
    longint best_age;
    int     best_lat;
    sel = 0;
    pend = 1'b0;
    best_age = STAGES + 1;
    best_lat = 0;
    if (rs == 5'd0) return;
    foreach (q[i]) begin
      if (q[i].rd == rs && (m_tick - q[i].birth) < best_age) begin
        best_age = m_tick - q[i].birth;
        best_lat = q[i].lat;
      end
    end
    if (best_age <= STAGES) begin
      if (best_age >= best_lat) sel = int'(best_age);
      else pend = 1'b1;
    end
  endfunction

  function automatic bit m_stall();
    int sel;
    bit pend;
    if (!ex_valid_i) return 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      m_src(rs_of(s), sel, pend);
      if (pend) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Advance one clock; update the model with the same inputs the DUT sees.
  task automatic tick();
    bit st, cap;
    st  = m_stall();
    cap = ex_valid_i && ex_wb_i && (ex_rd_i != 5'd0) && !flush_i && !st;
    @(posedge clk_i);
    if (!rst_i) begin
      q.delete();
      m_cnt = '0;
    end else if (!hold_i) begin
      if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (cap) q.push_back('{rd: ex_rd_i, lat: lat_of(ex_class_i), birth: m_tick});
      m_tick++;
      while (q.size() > 0 && (m_tick - q[0].birth) > STAGES) void'(q.pop_front());
    end
    #1;
  endtask

  task automatic set_ex(input bit v, input bit wb, input logic [4:0] rd,
                        input logic [1:0] cls, input logic [4:0] rs0, input logic [4:0] rs1);
    ex_valid_i = v;
    ex_wb_i    = wb;
    ex_rd_i    = rd;
    ex_class_i = cls;
    ex_rs_i    = {rs1, rs0};
  endtask

  task automatic do_reset();
    set_ex(0, 0, 0, 0, 0, 0);
    hold_i  = 1'b0;
    flush_i = 1'b0;
    rst_i   = 1'b0;
    tick();
    rst_i   = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    set_ex(1, 1, 3, 0, 5, 9);
    #1;
    n_tests++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", stall_o); end
    n_tests++; if (fwd_sel_o !== '0) begin n_fail++; $display("FAIL reset_sel: got %0h want 0", fwd_sel_o); end
    n_tests++; if (stall_cnt_o !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt_o); end
  endtask

  task automatic test_alu_forward();
    do_reset();
    set_ex(1, 1, 5, 0, 1, 2);
    tick();
    set_ex(1, 1, 6, 0, 5, 0);
    #1;
    n_tests++; if (sel_of(0) !== 1) begin n_fail++; $display("FAIL alu_sel_slot1: got %0d want 1", sel_of(0)); end
    n_tests++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL alu_no_stall: got %0b want 0", stall_o); end
    tick();
    set_ex(1, 0, 0, 0, 0, 5);
    #1;
    n_tests++; if (sel_of(1) !== 2) begin n_fail++; $display("FAIL alu_sel_slot2: got %0d want 2", sel_of(1)); end
    n_tests++; if (sel_of(0) !== 0) begin n_fail++; $display("FAIL alu_rs0_zero: got %0d want 0", sel_of(0)); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_ex(1, 1, 7, 1, 0, 0);
    tick();
    set_ex(1, 1, 8, 0, 7, 0);
    #1;
    n_tests++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL load_stall: got %0b want 1", stall_o); end
    n_tests++; if (sel_of(0) !== 0) begin n_fail++; $display("FAIL load_sel_pending: got %0d want 0", sel_of(0)); end
    tick();
    n_tests++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL load_release: got %0b want 0", stall_o); end
    n_tests++; if (sel_of(0) !== 2) begin n_fail++; $display("FAIL load_sel_slot2: got %0d want 2", sel_of(0)); end
    n_tests++; if (stall_cnt_o !== 32'd1) begin n_fail++; $display("FAIL load_cnt: got %0d want 1", stall_cnt_o); end
    tick();
  endtask

  task automatic test_mul_stall();
    do_reset();
    set_ex(1, 1, 9, 2, 0, 0);
    tick();
    set_ex(1, 1, 10, 0, 0, 9);
    for (int c = 0; c < MUL_LAT - 1; c++) begin
      #1;
      n_tests++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL mul_stall_c%0d: got %0b want 1", c, stall_o); end
      tick();
    end
    n_tests++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL mul_release: got %0b want 0", stall_o); end
    n_tests++; if (sel_of(1) !== MUL_LAT) begin n_fail++; $display("FAIL mul_sel: got %0d want %0d", sel_of(1), MUL_LAT); end
    n_tests++; if (stall_cnt_o !== 32'(MUL_LAT - 1)) begin n_fail++; $display("FAIL mul_cnt: got %0d want %0d", stall_cnt_o, MUL_LAT - 1); end
    tick();
  endtask

  task automatic test_youngest_x0();
    do_reset();
    set_ex(1, 1, 4, 0, 0, 0);
    tick();
    set_ex(1, 1, 4, 1, 0, 0);
    tick();
    set_ex(1, 1, 0, 0, 4, 0);
    #1;
    n_tests++; if (sel_of(0) !== 0 || stall_o !== 1'b1) begin n_fail++; $display("FAIL youngest_load_pending: got sel %0d stall %0b want 0 1", sel_of(0), stall_o); end
    tick();
    set_ex(1, 1, 0, 0, 4, 0);
    #1;
    n_tests++; if (sel_of(0) !== 2) begin n_fail++; $display("FAIL youngest_after_bubble: got %0d want 2", sel_of(0)); end
    do_reset();
    set_ex(1, 1, 4, 0, 0, 0);
    tick();
    tick();
    set_ex(1, 1, 0, 0, 4, 0);
    #1;
    n_tests++; if (sel_of(0) !== 1) begin n_fail++; $display("FAIL youngest_wins: got %0d want 1", sel_of(0)); end
    tick();
    set_ex(1, 0, 0, 0, 0, 0);
    #1;
    n_tests++; if (fwd_sel_o !== '0) begin n_fail++; $display("FAIL x0_no_forward: got %0h want 0", fwd_sel_o); end
    tick();
  endtask

  task automatic test_hold();
    do_reset();
    set_ex(1, 1, 7, 1, 0, 0);
    tick();
    set_ex(1, 1, 8, 0, 7, 0);
    hold_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests++; if (stall_o !== 1'b1 || stall_cnt_o !== 32'd0) begin n_fail++; $display("FAIL hold_frozen_c%0d: got stall %0b cnt %0d want 1 0", c, stall_o, stall_cnt_o); end
    end
    hold_i = 1'b0;
    tick();
    n_tests++; if (stall_o !== 1'b0 || sel_of(0) !== 2) begin n_fail++; $display("FAIL hold_release: got stall %0b sel %0d want 0 2", stall_o, sel_of(0)); end
    n_tests++; if (stall_cnt_o !== 32'd1) begin n_fail++; $display("FAIL hold_cnt: got %0d want 1", stall_cnt_o); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    set_ex(1, 1, 3, 0, 0, 0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    set_ex(1, 1, 11, 0, 3, 3);
    #1;
    n_tests++; if (fwd_sel_o !== '0 || stall_o !== 1'b0) begin n_fail++; $display("FAIL flush_squash: got sel %0h stall %0b want 0 0", fwd_sel_o, stall_o); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_ex(1, 1, 9, 2, 0, 0);
    tick();
    set_ex(1, 1, 12, 0, 9, 0);
    tick();
    rst_i  = 1'b0;
    hold_i = 1'b1;
    tick();
    rst_i  = 1'b1;
    hold_i = 1'b0;
    #1;
    n_tests++; if (stall_o !== 1'b0 || fwd_sel_o !== '0) begin n_fail++; $display("FAIL rst_mid_stall_out: got stall %0b sel %0h want 0 0", stall_o, fwd_sel_o); end
    n_tests++; if (stall_cnt_o !== 32'd0) begin n_fail++; $display("FAIL rst_mid_stall_cnt: got %0d want 0", stall_cnt_o); end
    tick();
  endtask

  task automatic test_random();
    int sel;
    bit pend;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      set_ex($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 5'($urandom_range(0, 7)),
             2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      hold_i  = ($urandom_range(0, 7) == 0);
      flush_i = ($urandom_range(0, 7) == 0);
      rst_i   = ($urandom_range(0, 99) != 0);
      #1;
      for (int s = 0; s < NUM_SRC; s++) begin
        m_src(rs_of(s), sel, pend);
        n_tests++; if (sel_of(s) !== sel) begin n_fail++; $display("FAIL rand_sel c%0d s%0d: got %0d want %0d", c, s, sel_of(s), sel); end
      end
      n_tests++; if (stall_o !== m_stall()) begin n_fail++; $display("FAIL rand_stall c%0d: got %0b want %0b", c, stall_o, m_stall()); end
      n_tests++; if (stall_cnt_o !== m_cnt) begin n_fail++; $display("FAIL rand_cnt c%0d: got %0d want %0d", c, stall_cnt_o, m_cnt); end
      tick();
    end
    rst_i   = 1'b1;
    hold_i  = 1'b0;
    flush_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu_forward();
    test_load_use();
    test_mul_stall();
    test_youngest_x0();
    test_hold();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
